// File: rtl/memory_responder.sv
// Byte-addressable big-endian RAM answering the MFA/MFC memory handshake.
// One request is latched per MFA assertion, completed after LATENCY wait cycles.
module memory_responder #(
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MFA,
    input  logic        READ_WRITE,
    input  logic        WORD_BYTE,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_rw;
    logic                    r_wb;
    logic [31:0]             r_din;
    logic [7:0]              r_mem [2**ADDR_WIDTH];

    logic                    w_fire;
    logic [ADDR_WIDTH-3:0]   w_word;
    logic [ADDR_WIDTH-1:0]   w_a0;
    logic [ADDR_WIDTH-1:0]   w_a1;
    logic [ADDR_WIDTH-1:0]   w_a2;
    logic [ADDR_WIDTH-1:0]   w_a3;
    logic                    w_unused;

    // Upper address bits alias onto the decoded range.
    assign w_unused = &{1'b0, Address[31:ADDR_WIDTH]};

    assign w_fire = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_word = r_addr[ADDR_WIDTH-1:2];
    assign w_a0   = r_wb ? {w_word, 2'b00} : r_addr;
    assign w_a1   = {w_word, 2'b01};
    assign w_a2   = {w_word, 2'b10};
    assign w_a3   = {w_word, 2'b11};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (MFA)    w_next = S_WAIT;
            S_WAIT:  if (w_fire) w_next = S_DONE;
            S_DONE:  if (!MFA)   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        MFC = (r_state == S_DONE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_wb    <= 1'b0;
            r_din   <= 32'd0;
            DataOut <= 32'd0;
        end else begin
            if (r_state == S_IDLE && MFA) begin
                r_addr <= Address[ADDR_WIDTH-1:0];
                r_rw   <= READ_WRITE;
                r_wb   <= WORD_BYTE;
                r_din  <= DataIn;
                r_cnt  <= 4'(LATENCY);
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_fire && r_rw) begin
                if (r_wb) begin
                    DataOut <= {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
                end else begin
                    DataOut <= {24'h0, r_mem[w_a0]};
                end
            end
        end
    end

    // Storage survives reset; a reset in WAIT forces IDLE so w_fire never asserts.
    always_ff @(posedge Clk) begin
        if (w_fire && !r_rw) begin
            if (r_wb) begin
                r_mem[w_a0] <= r_din[31:24];
                r_mem[w_a1] <= r_din[23:16];
                r_mem[w_a2] <= r_din[15:8];
                r_mem[w_a3] <= r_din[7:0];
            end else begin
                r_mem[w_a0] <= r_din[7:0];
            end
        end
    end

endmodule
